// File: rtl/eth_tx_axis_framer.sv
// rtl/eth_tx_axis_framer.sv - header/payload word stream to AXIS TX MAC framer with abort, drain and counters
module eth_tx_axis_framer #(
    parameter int axis_data_width_p = 64,
    parameter int size_width_p      = 16,
    parameter int count_width_p     = 16
) (
    input  logic                           clk_i,
    input  logic                           reset_i,
    input  logic [axis_data_width_p-1:0]   frame_data_i,
    input  logic                           frame_data_v_i,
    output logic                           frame_data_yumi_o,
    input  logic                           abort_i,
    output logic [1:0]                     tx_ext_state_o,
    output logic [axis_data_width_p-1:0]   tx_axis_tdata_o,
    output logic [axis_data_width_p/8-1:0] tx_axis_tkeep_o,
    output logic                           tx_axis_tvalid_o,
    input  logic                           tx_axis_tready_i,
    output logic                           tx_axis_tlast_o,
    output logic                           tx_axis_tuser_o,
    output logic                           header_err_o,
    output logic [count_width_p-1:0]       frames_sent_o,
    output logic [count_width_p-1:0]       frames_aborted_o
);

    localparam int B  = axis_data_width_p / 8;
    localparam int OW = $clog2(B);

    localparam logic [1:0] ST_HEADER  = 2'b00;
    localparam logic [1:0] ST_PAYLOAD = 2'b01;
    localparam logic [1:0] ST_DISCARD = 2'b10;

    logic [1:0]               state_q, state_d;
    logic [size_width_p-1:0]  ptr_q, ptr_d;
    logic [size_width_p-1:0]  end_q, end_d;
    logic [OW-1:0]            off_q, off_d;
    logic [OW-1:0]            rem_q, rem_d;
    logic                     err_q, err_d;
    logic                     abort_pending_q, abort_pending_d;
    logic                     header_err_q, header_err_d;
    logic [count_width_p-1:0] frames_sent_q, frames_sent_d;
    logic [count_width_p-1:0] frames_aborted_q, frames_aborted_d;

    // Header field decode; the offset is widened so it can be compared with the size.
    logic [size_width_p-1:0]  hdr_size;
    logic [OW-1:0]            hdr_off;
    logic                     hdr_err;
    logic [size_width_p-1:0]  hdr_off_ext;
    logic [size_width_p-1:0]  hdr_end;
    logic                     hdr_bad;

    assign hdr_size    = frame_data_i[size_width_p-1:0];
    assign hdr_off     = frame_data_i[size_width_p +: OW];
    assign hdr_err     = frame_data_i[size_width_p+OW];
    assign hdr_off_ext = size_width_p'(hdr_off);
    assign hdr_end     = (hdr_size - size_width_p'(1)) >> OW;
    assign hdr_bad     = (hdr_size == '0) || (hdr_off_ext >= hdr_size);

    // Beat qualifiers; everything AXIS-facing is forced low while reset is held.
    logic         in_payload;
    logic         abort_eff;
    logic         at_first;
    logic         at_end;
    logic         beat_last;
    logic         beat_valid;
    logic         yumi;
    logic [B-1:0] ones;
    logic [B-1:0] head_mask;
    logic [B-1:0] tail_mask;
    logic [B-1:0] keep;

    assign ones       = '1;
    assign in_payload = (state_q == ST_PAYLOAD) && !reset_i;
    assign abort_eff  = in_payload && (abort_i || abort_pending_q);
    assign at_first   = (ptr_q == '0);
    assign at_end     = (ptr_q == end_q);
    assign beat_last  = in_payload && (at_end || abort_eff);
    assign beat_valid = in_payload && frame_data_v_i;
    assign head_mask  = ones << off_q;
    assign tail_mask  = (rem_q == '0) ? ones : ~(ones << rem_q);

    // Byte enables: head mask on the first beat, tail mask on the natural last beat, both on a single-beat frame.
    always_comb begin
        keep = ones;
        if (at_first) begin
            keep = keep & head_mask;
        end
        if (at_end) begin
            keep = keep & tail_mask;
        end
    end

    // Consume handshake per state: headers and drained words are taken freely, payload waits on the MAC.
    always_comb begin
        yumi = 1'b0;
        if (!reset_i) begin
            case (state_q)
                ST_HEADER:  yumi = frame_data_v_i;
                ST_PAYLOAD: yumi = beat_valid && tx_axis_tready_i;
                ST_DISCARD: yumi = frame_data_v_i;
                default:    yumi = 1'b0;
            endcase
        end
    end

    assign frame_data_yumi_o = yumi;
    assign tx_ext_state_o    = state_q;
    assign tx_axis_tdata_o   = reset_i ? '0 : frame_data_i;
    assign tx_axis_tvalid_o  = beat_valid;
    assign tx_axis_tkeep_o   = in_payload ? keep : '0;
    assign tx_axis_tlast_o   = beat_last;
    assign tx_axis_tuser_o   = beat_last && (err_q || abort_eff);
    assign header_err_o      = header_err_q;
    assign frames_sent_o     = frames_sent_q;
    assign frames_aborted_o  = frames_aborted_q;

    // Next-state logic: header capture, payload beat accounting, abort latching and drain.
    always_comb begin
        state_d          = state_q;
        ptr_d            = ptr_q;
        end_d            = end_q;
        off_d            = off_q;
        rem_d            = rem_q;
        err_d            = err_q;
        abort_pending_d  = abort_pending_q;
        header_err_d     = 1'b0;
        frames_sent_d    = frames_sent_q;
        frames_aborted_d = frames_aborted_q;

        case (state_q)
            ST_HEADER: begin
                if (yumi) begin
                    off_d = hdr_off;
                    rem_d = hdr_size[OW-1:0];
                    err_d = hdr_err;
                    end_d = hdr_end;
                    ptr_d = '0;
                    if (hdr_bad) begin
                        header_err_d = 1'b1;
                    end else begin
                        state_d = ST_PAYLOAD;
                    end
                end
            end
            ST_PAYLOAD: begin
                if (yumi) begin
                    ptr_d           = ptr_q + size_width_p'(1);
                    abort_pending_d = 1'b0;
                    if (beat_last) begin
                        if (at_end) begin
                            state_d = ST_HEADER;
                            if (abort_eff) begin
                                frames_aborted_d = frames_aborted_q + count_width_p'(1);
                            end else begin
                                frames_sent_d = frames_sent_q + count_width_p'(1);
                            end
                        end else begin
                            frames_aborted_d = frames_aborted_q + count_width_p'(1);
                            state_d          = ST_DISCARD;
                        end
                    end
                end else if (abort_i) begin
                    abort_pending_d = 1'b1;
                end
            end
            ST_DISCARD: begin
                if (yumi) begin
                    ptr_d = ptr_q + size_width_p'(1);
                    if (at_end) begin
                        state_d = ST_HEADER;
                    end
                end
            end
            default: begin
                state_d = ST_HEADER;
            end
        endcase
    end

    // State registers with asynchronous clear.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q          <= ST_HEADER;
            ptr_q            <= '0;
            end_q            <= '0;
            off_q            <= '0;
            rem_q            <= '0;
            err_q            <= 1'b0;
            abort_pending_q  <= 1'b0;
            header_err_q     <= 1'b0;
            frames_sent_q    <= '0;
            frames_aborted_q <= '0;
        end else begin
            state_q          <= state_d;
            ptr_q            <= ptr_d;
            end_q            <= end_d;
            off_q            <= off_d;
            rem_q            <= rem_d;
            err_q            <= err_d;
            abort_pending_q  <= abort_pending_d;
            header_err_q     <= header_err_d;
            frames_sent_q    <= frames_sent_d;
            frames_aborted_q <= frames_aborted_d;
        end
    end

endmodule

// File: tb/tb_eth_tx_axis_framer.sv
// tb/tb_eth_tx_axis_framer.sv - scoreboard bench for eth_tx_axis_framer at 64 and 128 bit widths
module tb_eth_tx_axis_framer;

    typedef struct {
        logic [127:0] data;
        logic [15:0]  keep;
        logic         last;
        logic         user;
    } beat_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    logic [63:0]  d64;
    logic         v64, y64, ab64, rdy64, tv64, tl64, tu64, he64;
    logic [1:0]   st64;
    logic [63:0]  td64;
    logic [7:0]   tk64;
    logic [15:0]  fs64, fa64;

    logic [127:0] d128;
    logic         v128, y128, ab128, rdy128, tv128, tl128, tu128, he128;
    logic [1:0]   st128;
    logic [127:0] td128;
    logic [15:0]  tk128;
    logic [15:0]  fs128, fa128;

    eth_tx_axis_framer #(.axis_data_width_p(64), .size_width_p(16), .count_width_p(16)) u64 (
        .clk_i(clk), .reset_i(rst),
        .frame_data_i(d64), .frame_data_v_i(v64), .frame_data_yumi_o(y64),
        .abort_i(ab64), .tx_ext_state_o(st64),
        .tx_axis_tdata_o(td64), .tx_axis_tkeep_o(tk64), .tx_axis_tvalid_o(tv64),
        .tx_axis_tready_i(rdy64), .tx_axis_tlast_o(tl64), .tx_axis_tuser_o(tu64),
        .header_err_o(he64), .frames_sent_o(fs64), .frames_aborted_o(fa64)
    );

    eth_tx_axis_framer #(.axis_data_width_p(128), .size_width_p(16), .count_width_p(16)) u128 (
        .clk_i(clk), .reset_i(rst),
        .frame_data_i(d128), .frame_data_v_i(v128), .frame_data_yumi_o(y128),
        .abort_i(ab128), .tx_ext_state_o(st128),
        .tx_axis_tdata_o(td128), .tx_axis_tkeep_o(tk128), .tx_axis_tvalid_o(tv128),
        .tx_axis_tready_i(rdy128), .tx_axis_tlast_o(tl128), .tx_axis_tuser_o(tu128),
        .header_err_o(he128), .frames_sent_o(fs128), .frames_aborted_o(fa128)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int yumi_cnt64 = 0;
    int herr_cnt64 = 0;
    beat_t q64[$];
    beat_t q128[$];
    beat_t m64_b;
    beat_t m128_b;

    function automatic void chk(string name, logic [127:0] act, logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    function automatic logic [63:0] hdr64(int size, int off, int err);
        return 64'(size) | (64'(off) << 16) | (64'(err) << 19);
    endfunction

    function automatic logic [127:0] hdr128(int size, int off, int err);
        return 128'(size) | (128'(off) << 16) | (128'(err) << 20);
    endfunction

    function automatic void push64(logic [63:0] d, logic [7:0] k, logic l, logic u);
        beat_t b;
        b.data = 128'(d);
        b.keep = 16'(k);
        b.last = l;
        b.user = u;
        q64.push_back(b);
    endfunction

    function automatic void push128(logic [127:0] d, logic [15:0] k, logic l, logic u);
        beat_t b;
        b.data = d;
        b.keep = k;
        b.last = l;
        b.user = u;
        q128.push_back(b);
    endfunction

    // 64-bit monitor: pops the scoreboard on each accepted beat, tallies yumi and header errors
    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (y64) yumi_cnt64++;
                if (he64) herr_cnt64++;
                if (tv64 && rdy64) begin
                    if (q64.size() == 0) begin
                        n_cmp++;
                        n_bad++;
                        $display("FAIL unexpected_beat64: got tdata %0h expected no beat", td64);
                    end else begin
                        m64_b = q64.pop_front();
                        chk("tdata64", 128'(td64), m64_b.data);
                        chk("tkeep64", 128'(tk64), 128'(m64_b.keep));
                        chk("tlast64", 128'(tl64), 128'(m64_b.last));
                        chk("tuser64", 128'(tu64), 128'(m64_b.user));
                    end
                end
            end
        end
    end

    // 128-bit monitor
    initial begin
        forever begin
            @(negedge clk);
            if (!rst && tv128 && rdy128) begin
                if (q128.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_beat128: got tdata %0h expected no beat", td128);
                end else begin
                    m128_b = q128.pop_front();
                    chk("tdata128", td128, m128_b.data);
                    chk("tkeep128", 128'(tk128), 128'(m128_b.keep));
                    chk("tlast128", 128'(tl128), 128'(m128_b.last));
                    chk("tuser128", 128'(tu128), 128'(m128_b.user));
                end
            end
        end
    end

    task automatic send64(input logic [63:0] d, input int stall, input bit ab);
        int n;
        n = 0;
        d64 = d;
        v64 = 1'b1;
        forever begin
            rdy64 = (n >= stall);
            ab64  = ab && (n == 0) && (stall > 0);
            @(negedge clk);
            if (ab64) begin
                chk("abort_tlast", 128'(tl64), 128'(1));
                chk("abort_tuser", 128'(tu64), 128'(1));
            end else if (!rdy64) begin
                chk("held_tvalid", 128'(tv64), 128'(1));
                chk("held_tdata", 128'(td64), 128'(d));
            end
            if (y64) break;
            n++;
            if (n > 40) begin
                n_cmp++;
                n_bad++;
                $display("FAIL timeout64: got no yumi expected yumi within 40 cycles");
                break;
            end
            @(posedge clk);
            #1;
        end
        @(posedge clk);
        #1;
        v64   = 1'b0;
        ab64  = 1'b0;
        rdy64 = 1'b1;
    endtask

    task automatic send128(input logic [127:0] d);
        int n;
        n = 0;
        d128 = d;
        v128 = 1'b1;
        rdy128 = 1'b1;
        forever begin
            @(negedge clk);
            if (y128) break;
            n++;
            if (n > 40) begin
                n_cmp++;
                n_bad++;
                $display("FAIL timeout128: got no yumi expected yumi within 40 cycles");
                break;
            end
            @(posedge clk);
            #1;
        end
        @(posedge clk);
        #1;
        v128 = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish before 200us");
        $fatal(1);
    end

    initial begin
        int y0;
        int h0;
        rst = 1'b1;
        d64 = 64'hDEAD_BEEF_0123_4567; v64 = 1'b1; ab64 = 1'b0; rdy64 = 1'b1;
        d128 = '1; v128 = 1'b1; ab128 = 1'b0; rdy128 = 1'b1;
        #12;
        chk("rst_state", 128'(st64), 128'(0));
        chk("rst_tvalid", 128'(tv64), 128'(0));
        chk("rst_yumi", 128'(y64), 128'(0));
        chk("rst_tdata", 128'(td64), 128'(0));
        chk("rst_tdata128", td128, 128'(0));
        chk("rst_counters", 128'({fs64, fa64}), 128'(0));
        chk("rst_herr", 128'(he64), 128'(0));
        v64 = 1'b0;
        v128 = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;

        // three-beat frame, size 20
        y0 = yumi_cnt64;
        push64(64'h1111_0000_0000_0001, 8'hFF, 1'b0, 1'b0);
        push64(64'h1111_0000_0000_0002, 8'hFF, 1'b0, 1'b0);
        push64(64'h1111_0000_0000_0003, 8'h0F, 1'b1, 1'b0);
        send64(hdr64(20, 0, 0), 0, 1'b0);
        send64(64'h1111_0000_0000_0001, 0, 1'b0);
        send64(64'h1111_0000_0000_0002, 0, 1'b0);
        send64(64'h1111_0000_0000_0003, 0, 1'b0);
        chk("t1_yumi_count", 128'(yumi_cnt64 - y0), 128'(4));
        chk("t1_sent", 128'(fs64), 128'(1));
        chk("t1_state", 128'(st64), 128'(0));

        // single-beat frame with head offset 2, size 5
        push64(64'h2222_2222_2222_2222, 8'h1C, 1'b1, 1'b0);
        send64(hdr64(5, 2, 0), 0, 1'b0);
        send64(64'h2222_2222_2222_2222, 0, 1'b0);
        chk("t2_state", 128'(st64), 128'(0));
        chk("t2_sent", 128'(fs64), 128'(2));

        // error-flagged frame with tready stalls
        push64(64'h3333_0000_0000_0001, 8'hFF, 1'b0, 1'b0);
        push64(64'h3333_0000_0000_0002, 8'hFF, 1'b1, 1'b1);
        send64(hdr64(16, 0, 1), 0, 1'b0);
        send64(64'h3333_0000_0000_0001, 1, 1'b0);
        send64(64'h3333_0000_0000_0002, 1, 1'b0);
        chk("t3_sent", 128'(fs64), 128'(3));

        // abort on beat 3 of 8, then drain
        push64(64'h4444_0000_0000_0000, 8'hFF, 1'b0, 1'b0);
        push64(64'h4444_0000_0000_0001, 8'hFF, 1'b0, 1'b0);
        push64(64'h4444_0000_0000_0002, 8'hFF, 1'b1, 1'b1);
        send64(hdr64(64, 0, 0), 0, 1'b0);
        send64(64'h4444_0000_0000_0000, 0, 1'b0);
        send64(64'h4444_0000_0000_0001, 0, 1'b0);
        send64(64'h4444_0000_0000_0002, 1, 1'b1);
        chk("t4_state_discard", 128'(st64), 128'(2));
        for (int i = 3; i < 8; i++) begin
            send64(64'h4444_0000_0000_0000 | 64'(i), 0, 1'b0);
        end
        chk("t4_state_header", 128'(st64), 128'(0));
        chk("t4_aborted", 128'(fa64), 128'(1));
        chk("t4_sent", 128'(fs64), 128'(3));

        // invalid headers, then a valid frame
        h0 = herr_cnt64;
        send64(hdr64(0, 0, 0), 0, 1'b0);
        chk("t5_herr_a", 128'(he64), 128'(1));
        chk("t5_state_a", 128'(st64), 128'(0));
        send64(hdr64(4, 6, 0), 0, 1'b0);
        chk("t5_herr_b", 128'(he64), 128'(1));
        chk("t5_state_b", 128'(st64), 128'(0));
        @(posedge clk);
        #1;
        chk("t5_herr_low", 128'(he64), 128'(0));
        chk("t5_herr_count", 128'(herr_cnt64 - h0), 128'(2));
        push64(64'h5555_5555_5555_5555, 8'hFF, 1'b1, 1'b0);
        send64(hdr64(8, 0, 0), 0, 1'b0);
        send64(64'h5555_5555_5555_5555, 0, 1'b0);
        chk("t5_sent", 128'(fs64), 128'(4));

        // 128-bit: one normal frame, then size 17 offset 15 with reset during beat 2
        push128({64'h6666_0000_0000_0000, 64'h0}, 16'hFFFF, 1'b1, 1'b0);
        send128(hdr128(16, 0, 0));
        send128({64'h6666_0000_0000_0000, 64'h0});
        chk("t6_sent128", 128'(fs128), 128'(1));
        push128({64'h7777_0000_0000_0000, 64'h1}, 16'h8000, 1'b0, 1'b0);
        send128(hdr128(17, 15, 0));
        send128({64'h7777_0000_0000_0000, 64'h1});
        d128 = {64'h7777_0000_0000_0000, 64'h2};
        v128 = 1'b1;
        rdy128 = 1'b0;
        @(negedge clk);
        chk("t6_b2_tkeep", 128'(tk128), 128'(16'h0001));
        chk("t6_b2_tlast", 128'(tl128), 128'(1));
        chk("t6_b2_state", 128'(st128), 128'(1));
        #2;
        rst = 1'b1;
        #1;
        chk("t6_rst_state128", 128'(st128), 128'(0));
        chk("t6_rst_count128", 128'({fs128, fa128}), 128'(0));
        chk("t6_rst_tvalid128", 128'(tv128), 128'(0));
        chk("t6_rst_tkeep128", 128'(tk128), 128'(0));
        chk("t6_rst_count64", 128'({fs64, fa64}), 128'(0));
        v128 = 1'b0;
        rdy128 = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("q64_drained", 128'(q64.size()), 128'(0));
        chk("q128_drained", 128'(q128.size()), 128'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
